data_bus_responder: RTL and testbench
=====================================

# data_bus_responder

Data-side bus responder for the pipelined CPU. It answers the CPU's data-memory port (address, write data, write enable, read data) with a word-addressed RAM and a small memory-mapped I/O window. The window holds an LED register, a free-running cycle counter and a 4-entry transmit FIFO that drains over a valid/ready byte port. It sits beside the instruction memory at top level and is the responder end of the CPU data bus.

## Interface
- DATA_WIDTH, 32, data word width; must match the CPU data path.
- ADDR_WIDTH, 16, word-address width of `dataAddr`.
- RAM_WORDS, 256, RAM depth in words (power of two, ≤ 0x8000).
- TX_DEPTH, 4, transmit FIFO depth (power of two).
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- dataAddr  in  ADDR_WIDTH  word address from the CPU.
- dataWrData  in  DATA_WIDTH  store data from the CPU.
- dataWrEnable  in  1  store strobe; one word is written per cycle it is high.
- dataRdData  out  DATA_WIDTH  read data; combinational from `dataAddr`.
- led  out  8  LED register bits [7:0].
- txData  out  8  byte at the FIFO head.
- txValid  out  1  FIFO not empty.
- txReady  in  1  consumer accepts the head byte when `txValid` and `txReady` are both high.

## Operation
- Address map (word addresses):
  - 0x0000..RAM_WORDS-1: RAM, read/write.
  - 0x8000: LED register (R/W). A write stores bits [7:0]; a read returns them zero-extended.
  - 0x8001: cycle counter (R/W). A read returns the current value. A write loads `dataWrData`.
  - 0x8002: TX push (write only). A write pushes bits [7:0]. A read returns 0.
  - 0x8003: status (R/W1C). Reads as: bit0 full, bit1 empty, bit2 overflow (sticky), bits[6:4] occupancy (0..TX_DEPTH), other bits 0. A write with bit2 set clears overflow.
  - Any other address, including RAM_WORDS..0x7FFF: reads 0, writes ignored.
- Reads have no side effects. The CPU drives `dataAddr` every cycle, including for squashed instructions.
- RAM addressing uses the low log2(RAM_WORDS) address bits, only when the address is below RAM_WORDS.
- RAM contents are not reset. Reads of never-written RAM words are undefined, so benches must initialise before reading.
- Cycle counter: +1 every cycle; 0xFFFFFFFF wraps to 0. In a cycle with a write to 0x8001, the next value is the written value, not +1.
- TX FIFO circular buffer, head/tail pointers plus occupancy count:
  - Pop when `txValid` && `txReady`.
  - Push when a write to 0x8002 arrives and (not full, or a pop happens in the same cycle).
  - Push while full with no pop: the byte is dropped and overflow is set.
  - Push and pop in the same cycle: both take effect and occupancy is unchanged.
  - No pop when empty (`txValid` is low); a push into an empty FIFO is accepted normally.
  - Pointers wrap modulo TX_DEPTH.
  - If overflow is set and cleared in the same cycle, set wins.

## Timing
- Reset (`rst` low) takes effect asynchronously and holds while low:
  - led = 0, counter = 0, FIFO empty, overflow = 0, txValid = 0, txData = 0.
  - dataRdData follows its combinational decode (RAM reads undefined).
- Read latency is 0 cycles: `dataRdData` is a combinational function of `dataAddr` and the current state.
- Write latency is 1 edge. A same-cycle read of the address being written returns the old value; the new value is readable the next cycle.
- Push to `txValid` latency: `txValid` rises the cycle after the push edge. `txData` is the registered head entry.
- Release of `rst` mid-operation: the FIFO is empty and the counter restarts from 0 on the first edge after release. A store presented during reset is lost.

## Configuration
- DBUS_CYCLE_COUNTER_EN:
  - Defined: the counter at 0x8001 is present as described.
  - Undefined: no counter flops. 0x8001 reads 0 and writes to it are ignored.

## Test plan
- RAM: write 0xDEADBEEF to 0x0005, read 0x0005 in the same cycle → old value; next cycle → 0xDEADBEEF. Read 0x0105 (RAM_WORDS=256) → 0.
- LED/unmapped: write 0x1234_56A5 to 0x8000 → led = 0xA5 next cycle, read 0x8000 = 0x000000A5. Write to 0x7000 → no state change, read 0x7000 = 0.
- Counter (macro on): write 0xFFFFFFFE to 0x8001 → next cycle reads 0xFFFFFFFE, then 0xFFFFFFFF, then 0x00000000. Macro off → reads 0.
- FIFO fill/overflow: hold txReady = 0, push 0x11,0x22,0x33,0x44,0x55 → status = 0x041 then 0x045 (overflow set). Raise txReady → bytes out 0x11..0x44, then txValid = 0 and status = 0x006.
- Simultaneous: FIFO full, txReady = 1, push 0x66 in the same cycle → occupancy stays 4, no overflow, 0x66 emerges last. Write 0x4 to 0x8003 → overflow cleared.
- Async reset mid-stream: assert rst low between edges with 2 bytes queued → txValid = 0 and led = 0 immediately; after release, status = 0x002.

Source files
------------

// File: rtl/data_bus_responder.sv
// Data-side bus responder: word RAM plus an I/O window (LED, cycle counter, TX byte FIFO).
// Optional feature macro: DBUS_CYCLE_COUNTER_EN enables the cycle counter at 0x8001.
`timescale 1ns/1ps

module data_bus_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int RAM_WORDS  = 256,
  parameter int TX_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] dataAddr,
  input  logic [DATA_WIDTH-1:0] dataWrData,
  input  logic                  dataWrEnable,
  output logic [DATA_WIDTH-1:0] dataRdData,
  output logic [7:0]            led,
  output logic [7:0]            txData,
  output logic                  txValid,
  input  logic                  txReady
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int PTR_W  = $clog2(TX_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [ADDR_WIDTH-1:0] ADDR_LED     = ADDR_WIDTH'(32'h8000);
  localparam logic [ADDR_WIDTH-1:0] ADDR_COUNTER = ADDR_WIDTH'(32'h8001);
  localparam logic [ADDR_WIDTH-1:0] ADDR_TXPUSH  = ADDR_WIDTH'(32'h8002);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS  = ADDR_WIDTH'(32'h8003);

  // Address decode
  logic              isRam;
  logic [RAM_AW-1:0] ramIdx;
  logic              wrRam;
  logic              wrLed;
  logic              wrPush;
  logic              wrStatus;

  assign isRam    = dataAddr < ADDR_WIDTH'(RAM_WORDS);
  assign ramIdx   = dataAddr[RAM_AW-1:0];
  assign wrRam    = dataWrEnable && isRam;
  assign wrLed    = dataWrEnable && (dataAddr == ADDR_LED);
  assign wrPush   = dataWrEnable && (dataAddr == ADDR_TXPUSH);
  assign wrStatus = dataWrEnable && (dataAddr == ADDR_STATUS);

  // RAM: combinational read, not reset; stores are suppressed while reset is held.
  logic [DATA_WIDTH-1:0] ramMem [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (rst && wrRam) begin
      ramMem[ramIdx] <= dataWrData;
    end
  end

  // LED register
  logic [7:0] ledReg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ledReg <= '0;
    end else if (wrLed) begin
      ledReg <= dataWrData[7:0];
    end
  end

  assign led = ledReg;

  // Cycle counter
  logic [DATA_WIDTH-1:0] counterRd;

`ifdef DBUS_CYCLE_COUNTER_EN
  logic                  wrCounter;
  logic [DATA_WIDTH-1:0] cycleCount;

  assign wrCounter = dataWrEnable && (dataAddr == ADDR_COUNTER);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycleCount <= '0;
    end else if (wrCounter) begin
      cycleCount <= dataWrData;
    end else begin
      cycleCount <= cycleCount + DATA_WIDTH'(1);
    end
  end

  assign counterRd = cycleCount;
`else
  assign counterRd = '0;
`endif

  // TX FIFO: circular buffer with separate occupancy count so full/empty are unambiguous.
  logic [7:0]       fifoMem [TX_DEPTH];
  logic [PTR_W-1:0] headPtr;
  logic [PTR_W-1:0] tailPtr;
  logic [CNT_W-1:0] txCount;
  logic             overflowReg;
  logic             fifoFull;
  logic             fifoEmpty;
  logic             doPop;
  logic             doPush;
  logic             overflowSet;
  logic             overflowClr;

  assign fifoFull    = (txCount == CNT_W'(TX_DEPTH));
  assign fifoEmpty   = (txCount == '0);
  assign doPop       = txValid && txReady;
  assign doPush      = wrPush && (!fifoFull || doPop);
  assign overflowSet = wrPush && fifoFull && !doPop;
  assign overflowClr = wrStatus && dataWrData[2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      headPtr     <= '0;
      tailPtr     <= '0;
      txCount     <= '0;
      overflowReg <= 1'b0;
      for (int i = 0; i < TX_DEPTH; i++) begin
        fifoMem[i] <= '0;
      end
    end else begin
      if (doPush) begin
        fifoMem[tailPtr] <= dataWrData[7:0];
        tailPtr          <= tailPtr + PTR_W'(1);
      end
      if (doPop) begin
        headPtr <= headPtr + PTR_W'(1);
      end
      case ({doPush, doPop})
        2'b10:   txCount <= txCount + CNT_W'(1);
        2'b01:   txCount <= txCount - CNT_W'(1);
        default: txCount <= txCount;
      endcase
      // A set in the same cycle as a clear takes priority.
      if (overflowSet) begin
        overflowReg <= 1'b1;
      end else if (overflowClr) begin
        overflowReg <= 1'b0;
      end
    end
  end

  assign txValid = !fifoEmpty;
  assign txData  = fifoMem[headPtr];

  // Read mux: side-effect free, so squashed loads are harmless.
  logic [DATA_WIDTH-1:0] statusWord;

  always_comb begin
    statusWord      = '0;
    statusWord[0]   = fifoFull;
    statusWord[1]   = fifoEmpty;
    statusWord[2]   = overflowReg;
    statusWord[6:4] = 3'(txCount);
  end

  always_comb begin
    dataRdData = '0;
    if (isRam) begin
      dataRdData = ramMem[ramIdx];
    end else begin
      case (dataAddr)
        ADDR_LED:     dataRdData = DATA_WIDTH'(ledReg);
        ADDR_COUNTER: dataRdData = counterRd;
        ADDR_STATUS:  dataRdData = statusWord;
        default:      dataRdData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench for data_bus_responder: RAM, LED, counter, TX FIFO and async reset.
`timescale 1ns/1ps

module tb_data_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] dataAddr;
  logic [31:0] dataWrData;
  logic        dataWrEnable;
  logic [31:0] dataRdData;
  logic [7:0]  led;
  logic [7:0]  txData;
  logic        txValid;
  logic        txReady;

  int totalCnt = 0;
  int badCnt   = 0;

  always #5 clk = ~clk;

  data_bus_responder dut (
    .clk          (clk),
    .rst          (rst),
    .dataAddr     (dataAddr),
    .dataWrData   (dataWrData),
    .dataWrEnable (dataWrEnable),
    .dataRdData   (dataRdData),
    .led          (led),
    .txData       (txData),
    .txValid      (txValid),
    .txReady      (txReady)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalCnt++;
    if (got !== exp) begin
      badCnt++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic setBus(input logic [15:0] a, input logic [31:0] d, input logic we);
    dataAddr     = a;
    dataWrData   = d;
    dataWrEnable = we;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input string tag, input logic [15:0] a, input logic [31:0] exp);
    setBus(a, 32'h0, 1'b0);
    #1;
    checkVal(tag, dataRdData, exp);
  endtask

  logic [7:0] fillBytes [5];
  logic [7:0] simBytes  [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fillBytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    simBytes  = '{8'hA2, 8'hA3, 8'hA4, 8'h66};
    rst     = 1'b0;
    txReady = 1'b0;
    setBus(16'h0000, 32'h0, 1'b0);
    tick();
    tick();

    // Reset state
    checkVal("rst_led", {24'h0, led}, 32'h0);
    checkVal("rst_txValid", {31'h0, txValid}, 32'h0);
    checkVal("rst_txData", {24'h0, txData}, 32'h0);
    peek("rst_status", 16'h8003, 32'h0000_0002);
    #2;
    rst = 1'b1;
    tick();

    // RAM
    setBus(16'h0005, 32'h0, 1'b1);
    tick();
    setBus(16'h0005, 32'hDEAD_BEEF, 1'b1);
    #1;
    checkVal("ram_same_cycle_old", dataRdData, 32'h0);
    tick();
    peek("ram_new", 16'h0005, 32'hDEAD_BEEF);
    peek("ram_oob_0105", 16'h0105, 32'h0);
    setBus(16'h0105, 32'h1234_5678, 1'b1);
    tick();
    peek("ram_no_alias", 16'h0005, 32'hDEAD_BEEF);
    setBus(16'h00FF, 32'hCAFE_0001, 1'b1);
    tick();
    peek("ram_last_word", 16'h00FF, 32'hCAFE_0001);
    peek("ram_oob_0100", 16'h0100, 32'h0);

    // LED and unmapped
    setBus(16'h8000, 32'h1234_56A5, 1'b1);
    #1;
    checkVal("led_same_cycle_old", dataRdData, 32'h0);
    tick();
    checkVal("led_port", {24'h0, led}, 32'h0000_00A5);
    peek("led_read", 16'h8000, 32'h0000_00A5);
    setBus(16'h7000, 32'hFFFF_FFFF, 1'b1);
    tick();
    peek("unmapped_read", 16'h7000, 32'h0);
    checkVal("unmapped_led_kept", {24'h0, led}, 32'h0000_00A5);
    peek("txpush_reads_zero", 16'h8002, 32'h0);

    // Cycle counter
    setBus(16'h8001, 32'hFFFF_FFFE, 1'b1);
    tick();
`ifdef DBUS_CYCLE_COUNTER_EN
    peek("cnt_loaded", 16'h8001, 32'hFFFF_FFFE);
    tick();
    peek("cnt_max", 16'h8001, 32'hFFFF_FFFF);
    tick();
    peek("cnt_wrap", 16'h8001, 32'h0000_0000);
`else
    peek("cnt_absent", 16'h8001, 32'h0);
    tick();
    peek("cnt_absent_later", 16'h8001, 32'h0);
`endif

    // FIFO fill and overflow
    for (int i = 0; i < 4; i++) begin
      setBus(16'h8002, {24'h0, fillBytes[i]}, 1'b1);
      tick();
    end
    peek("fifo_full_status", 16'h8003, 32'h0000_0041);
    checkVal("fifo_head_11", {24'h0, txData}, 32'h11);
    setBus(16'h8002, {24'h0, fillBytes[4]}, 1'b1);
    tick();
    peek("fifo_overflow_status", 16'h8003, 32'h0000_0045);
    txReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkVal($sformatf("drain_%0d", i), {24'h0, txData}, {24'h0, fillBytes[i]});
      tick();
    end
    checkVal("drain_txValid_low", {31'h0, txValid}, 32'h0);
    peek("drain_status", 16'h8003, 32'h0000_0006);
    txReady = 1'b0;

    // W1C: only bit2 clears overflow
    setBus(16'h8003, 32'h0000_0003, 1'b1);
    tick();
    peek("w1c_bit2_clear_kept", 16'h8003, 32'h0000_0006);
    setBus(16'h8003, 32'h0000_0004, 1'b1);
    tick();
    peek("w1c_cleared", 16'h8003, 32'h0000_0002);

    // Simultaneous push and pop while full
    for (int i = 0; i < 4; i++) begin
      setBus(16'h8002, 32'h0000_00A1 + 32'(i), 1'b1);
      tick();
    end
    peek("sim_full_status", 16'h8003, 32'h0000_0041);
    txReady = 1'b1;
    setBus(16'h8002, 32'h0000_0066, 1'b1);
    tick();
    peek("sim_status_after", 16'h8003, 32'h0000_0041);
    for (int i = 0; i < 4; i++) begin
      checkVal($sformatf("sim_drain_%0d", i), {24'h0, txData}, {24'h0, simBytes[i]});
      tick();
    end
    checkVal("sim_txValid_low", {31'h0, txValid}, 32'h0);
    txReady = 1'b0;

    // Async reset mid-stream
    setBus(16'h8002, 32'h0000_0077, 1'b1);
    tick();
    setBus(16'h8002, 32'h0000_0088, 1'b1);
    tick();
    setBus(16'h0000, 32'h0, 1'b0);
    checkVal("pre_reset_txValid", {31'h0, txValid}, 32'h1);
    #3;
    rst = 1'b0;
    setBus(16'h8000, 32'h0000_00FF, 1'b1);
    #1;
    checkVal("async_txValid", {31'h0, txValid}, 32'h0);
    checkVal("async_led", {24'h0, led}, 32'h0);
    checkVal("async_txData", {24'h0, txData}, 32'h0);
    tick();
    tick();
    setBus(16'h0000, 32'h0, 1'b0);
    #2;
    rst = 1'b1;
    peek("post_reset_status", 16'h8003, 32'h0000_0002);
`ifdef DBUS_CYCLE_COUNTER_EN
    peek("post_reset_cnt0", 16'h8001, 32'h0);
`endif
    tick();
    checkVal("store_in_reset_lost", {24'h0, led}, 32'h0);
`ifdef DBUS_CYCLE_COUNTER_EN
    peek("post_reset_cnt1", 16'h8001, 32'h1);
`else
    peek("post_reset_cnt_absent", 16'h8001, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
    $finish;
  end

endmodule
